sorted_ram_loader: RTL

Upstream fill stage for the binary search datapath. It accepts a stream of 8-bit values on a valid/ready handshake and writes them into the 32x8 single-port RAM by in-place insertion sort. The RAM is therefore always ascending over entries 0..count-1 when the block is idle. The searcher reads the RAM only while this block reports `done`; the two blocks share the RAM port through a top-level mux selected by `done`.

---
 rtl/sorted_ram_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sorted_ram_loader.sv
// Insertion-sort fill stage: writes an accepted value into the external RAM so that it stays ascending.
// Optional macro SORTED_LOADER_DROP_EN: accept and discard values while full instead of backpressuring.
module sorted_ram_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  done,
  output logic                  dropped
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_COMPARE,
    S_INSERT
  } state_e;

  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] v_q, v_d;
  logic [ADDR_WIDTH:0]   i_q, i_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   i_plus1;
  logic                  transfer;

  assign i_plus1  = i_q + ONE;
  assign transfer = in_valid & in_ready;
  assign count    = count_q;
  // count never exceeds 2^ADDR_WIDTH, so its top bit alone means full.
  assign full     = count_q[ADDR_WIDTH];
  assign done     = (state_q == S_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      v_q     <= '0;
      i_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      i_q     <= i_d;
      count_q <= count_d;
    end
  end

  // NOTE: every output of this block is given a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    i_d       = i_q;
    count_d   = count_q;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (transfer && !full) begin
            v_d = in_data;
            if (count_q == '0) begin
              state_d = S_INSERT;
            end else begin
              i_d     = count_q - ONE;
              state_d = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          ram_addr = i_q[ADDR_WIDTH-1:0];
          state_d  = S_COMPARE;
        end
        S_COMPARE: begin
          ram_wren = 1'b1;
          ram_addr = i_plus1[ADDR_WIDTH-1:0];
          // Strict compare keeps equal values in arrival order.
          if (ram_q > v_q) begin
            ram_wdata = ram_q;
            if (i_q == '0) begin
              state_d = S_INSERT;
            end else begin
              i_d     = i_q - ONE;
              state_d = S_ISSUE;
            end
          end else begin
            ram_wdata = v_q;
            count_d   = count_q + ONE;
            state_d   = S_IDLE;
          end
        end
        S_INSERT: begin
          ram_wren  = 1'b1;
          ram_wdata = v_q;
          count_d   = count_q + ONE;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef SORTED_LOADER_DROP_EN
  logic dropped_q, dropped_d;

  assign in_ready  = (state_q == S_IDLE) & ~clear & ~reset;
  assign dropped_d = transfer & full;
  assign dropped   = dropped_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dropped_q <= 1'b0;
    else       dropped_q <= dropped_d;
  end
`else
  assign in_ready = (state_q == S_IDLE) & ~full & ~clear & ~reset;
  assign dropped  = 1'b0;
`endif

endmodule
